dcache_ctrl_param: RTL and testbench

Parametrised write-back, direct-mapped data cache controller. It sits between the pipeline MEM stage and the block-wide data memory, and replaces the fixed 8-set, 4-word controller. Loads are sign- or zero-extended by FUNC3 and ADDRESS[1:0], stores use per-byte write-enables, and misaligned accesses are flagged. The block owns the tag/valid/dirty arrays, the data array and the refill/write-back FSM.

---
 rtl/dcache_ctrl_param.sv | 174 +++++++++++++++++
 tb/tb_dcache_ctrl_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_param.sv
// Parametrised write-back, direct-mapped data cache controller: extended loads,
// byte-enable stores, misalignment detection and a refill/write-back FSM.
module dcache_ctrl_param #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic                               READ_EN,
  input  logic                               WRITE_EN,
  input  logic [31:0]                        ADDRESS,
  input  logic [31:0]                        WRITEDATA,
  input  logic [2:0]                         FUNC3,
  output logic [31:0]                        READ_DATA,
  output logic                               BUSYWAIT,
  output logic                               MISALIGN,
  output logic                               MEM_READ,
  output logic                               MEM_WRITE,
  output logic [29-$clog2(LINE_WORDS):0]     MEM_ADDRESS,
  output logic [32*LINE_WORDS-1:0]           MEM_WRITEDATA,
  input  logic [32*LINE_WORDS-1:0]           MEM_READDATA,
  input  logic                               MEM_BUSYWAIT
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t              state;
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
  logic [LINE_W-1:0]   data_arr [NUM_SETS];
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic                mem_seen;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [WSEL_W-1:0] a_word;
  logic [1:0]        a_byte;

  assign a_tag  = ADDRESS[31 -: TAG_W];
  assign a_idx  = ADDRESS[OFF_W +: IDX_W];
  assign a_byte = ADDRESS[1:0];

  generate
    if (LINE_WORDS > 1) begin : g_wsel
      assign a_word = ADDRESS[OFF_W-1:2];
    end else begin : g_wsel_single
      assign a_word = '0;
    end
  endgenerate

  logic        req, mis, hit, done, store_hit, alloc_done;
  logic [31:0] cur_word, load_word, store_word, st_data, be_mask;
  logic [3:0]  be;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    req = READ_EN | WRITE_EN;
    mis = 1'b0;
    if ((FUNC3 == 3'b001 || FUNC3 == 3'b101) && a_byte[0]) mis = 1'b1;
    if (FUNC3 == 3'b010 && a_byte != 2'b00) mis = 1'b1;
    hit      = valid[a_idx] && (tag_arr[a_idx] == a_tag);
    cur_word = data_arr[a_idx][{a_word, 5'd0} +: 32];
    sel_b    = cur_word[{a_byte, 3'd0} +: 8];
    sel_h    = cur_word[{a_byte[1], 4'd0} +: 16];
    case (FUNC3)
      3'b000:  load_word = {{24{sel_b[7]}}, sel_b};
      3'b100:  load_word = {24'd0, sel_b};
      3'b001:  load_word = {{16{sel_h[15]}}, sel_h};
      3'b101:  load_word = {16'd0, sel_h};
      default: load_word = cur_word;
    endcase
    case (FUNC3)
      3'b000: begin
        be      = 4'b0001 << a_byte;
        st_data = {4{WRITEDATA[7:0]}};
      end
      3'b001: begin
        be      = 4'b0011 << a_byte;
        st_data = {2{WRITEDATA[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = WRITEDATA;
      end
    endcase
    be_mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    store_word = (cur_word & ~be_mask) | (st_data & be_mask);
    done       = mem_seen && !MEM_BUSYWAIT;
    store_hit  = (state == IDLE) && WRITE_EN && !mis && hit;
    alloc_done = (state == ALLOCATE) && done;
  end

  assign MISALIGN  = RESET && req && mis;
  assign BUSYWAIT  = RESET && ((state != IDLE) || (req && !mis && !hit));
  assign READ_DATA = (READ_EN && !WRITE_EN && !mis && hit && state == IDLE) ? load_word : '0;

  always_ff @(posedge CLOCK) begin
    if (alloc_done) begin
      data_arr[req_idx] <= MEM_READDATA;
      tag_arr[req_idx]  <= req_tag;
    end else if (store_hit) begin
      data_arr[a_idx][{a_word, 5'd0} +: 32] <= store_word;
    end
  end

  // The missing line's tag/index are latched so the refill completes even if the request drops.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      req_tag       <= '0;
      req_idx       <= '0;
      mem_seen      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_seen <= 1'b0;
          if (store_hit) begin
            dirty[a_idx] <= 1'b1;
          end else if (req && !mis && !hit) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            if (valid[a_idx] && dirty[a_idx]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_arr[a_idx], a_idx};
              MEM_WRITEDATA <= data_arr[a_idx];
            end else begin
              state       <= ALLOCATE;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {a_tag, a_idx};
            end
          end
        end
        WRITEBACK: begin
          if (done) begin
            state       <= ALLOCATE;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {req_tag, req_idx};
            mem_seen    <= 1'b0;
          end else if (MEM_BUSYWAIT) begin
            mem_seen <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (done) begin
            state          <= IDLE;
            MEM_READ       <= 1'b0;
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            mem_seen       <= 1'b0;
          end else if (MEM_BUSYWAIT) begin
            mem_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl_param.sv
// Scoreboard bench for dcache_ctrl_param: a flat-memory reference model predicts
// every load; a block memory model with random latency serves refills/write-backs.
module tb_dcache_ctrl_param;
  localparam int NS     = 8;
  localparam int LW     = 4;
  localparam int OFF_W  = $clog2(LW) + 2;
  localparam int BLK_W  = 32 - OFF_W;
  localparam int LINE_W = 32 * LW;
  localparam logic [31:0] SPAN = NS * LW * 4;

  logic              CLOCK, RESET, READ_EN, WRITE_EN;
  logic [31:0]       ADDRESS, WRITEDATA, READ_DATA;
  logic [2:0]        FUNC3;
  logic              BUSYWAIT, MISALIGN, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [BLK_W-1:0]  MEM_ADDRESS;
  logic [LINE_W-1:0] MEM_WRITEDATA, MEM_READDATA;

  dcache_ctrl_param #(.NUM_SETS(NS), .LINE_WORDS(LW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .READ_EN(READ_EN), .WRITE_EN(WRITE_EN),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .FUNC3(FUNC3),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGN(MISALIGN),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  typedef struct { bit mis; bit is_rd; logic [31:0] data; } exp_t;
  typedef struct { bit w; int unsigned a; } mtx_t;
  exp_t sbq[$];
  mtx_t mlog[$];

  logic [31:0]       ref_mem [int unsigned];
  logic [LINE_W-1:0] bk      [int unsigned];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [LINE_W-1:0] blk_line(int unsigned b);
    logic [LINE_W-1:0] l;
    if (bk.exists(b)) return bk[b];
    for (int unsigned w = 0; w < LW; w++) l[w*32 +: 32] = init_word(b * LW + w);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(int unsigned b);
    logic [LINE_W-1:0] l;
    for (int unsigned w = 0; w < LW; w++) l[w*32 +: 32] = ref_rd(b * LW + w);
    return l;
  endfunction

  function automatic bit exp_mis(logic [2:0] f3, logic [31:0] a);
    return ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] exp_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_rd(a >> 2);
    b = 8'(w >> (8 * a[1:0]));
    h = 16'(w >> (16 * a[1]));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic void ref_store(logic [31:0] a, logic [2:0] f3, logic [31:0] wd);
    logic [31:0] w;
    int unsigned by;
    w  = ref_rd(a >> 2);
    by = a[1:0];
    case (f3)
      3'd0:    w[8*by +: 8]  = wd[7:0];
      3'd1:    w[8*by +: 16] = wd[15:0];
      default: w = wd;
    endcase
    ref_mem[a >> 2] = w;
  endfunction

  function automatic void preload(int unsigned wa, logic [31:0] v);
    logic [LINE_W-1:0] l;
    ref_mem[wa] = v;
    l = blk_line(wa / LW);
    l[(wa % LW)*32 +: 32] = v;
    bk[wa / LW] = l;
  endfunction

  // After reset the cache contents are gone, so the visible memory is the backing store.
  function automatic void ref_resync();
    ref_mem.delete();
    foreach (bk[b])
      for (int unsigned w = 0; w < LW; w++) ref_mem[b * LW + w] = bk[b][w*32 +: 32];
  endfunction

  // Block memory: busy for 1..3 cycles per strobe, then one quiet cycle.
  initial begin
    int mstate;
    int cnt;
    bit is_w;
    int unsigned maddr;
    mtx_t t;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    mstate = 0;
    cnt = 0;
    is_w = 1'b0;
    maddr = 0;
    forever begin
      @(negedge CLOCK);
      if (!RESET) begin
        MEM_BUSYWAIT = 1'b0;
        mstate = 0;
      end else begin
        case (mstate)
          0: if (MEM_READ || MEM_WRITE) begin
               is_w = MEM_WRITE;
               maddr = MEM_ADDRESS;
               t.w = is_w;
               t.a = maddr;
               mlog.push_back(t);
               cnt = $urandom_range(1, 3);
               MEM_BUSYWAIT = 1'b1;
               mstate = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 if (is_w) begin
                   chk("wb_line", MEM_WRITEDATA == ref_line(maddr), 1);
                   bk[maddr] = MEM_WRITEDATA;
                 end else begin
                   MEM_READDATA = blk_line(maddr);
                 end
                 MEM_BUSYWAIT = 1'b0;
                 mstate = 2;
               end
             end
          default: mstate = 0;
        endcase
      end
    end
  end

  // Monitor: pops one expectation whenever the DUT completes or rejects a request.
  always @(negedge CLOCK) begin
    exp_t e;
    if (RESET) begin
      if (MEM_READ && MEM_WRITE) chk("strobe_overlap", 1, 0);
      if (READ_EN || WRITE_EN) begin
        if (MISALIGN || !BUSYWAIT) begin
          if (sbq.size() == 0) begin
            chk("unexpected_response", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("misalign", MISALIGN, e.mis);
            if (e.mis) begin
              chk("mis_strobes", MEM_READ | MEM_WRITE, 0);
              chk("mis_busy", BUSYWAIT, 0);
            end else if (e.is_rd) begin
              chk("read_data", READ_DATA, e.data);
            end
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        chk("idle_rdata", READ_DATA, 0);
      end
    end
  end

  task automatic access(input bit re, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    e.mis   = exp_mis(f3, a);
    e.is_rd = re && !we;
    e.data  = e.is_rd ? exp_load(a, f3) : 32'd0;
    if (we && !e.mis) ref_store(a, f3, wd);
    sbq.push_back(e);
    @(posedge CLOCK); #1;
    READ_EN = re; WRITE_EN = we; FUNC3 = f3; ADDRESS = a; WRITEDATA = wd;
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (BUSYWAIT && n < 200);
    if (BUSYWAIT) chk("busy_timeout", 1, 0);
    @(posedge CLOCK); #1;
    READ_EN = 1'b0; WRITE_EN = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] conf, ra, a, wd;
    logic [2:0]  f3;
    bit          we, re;
    int          n;
    RESET = 1'b0; READ_EN = 1'b0; WRITE_EN = 1'b0;
    ADDRESS = '0; WRITEDATA = '0; FUNC3 = '0;
    conf = 32'h40 + SPAN;
    ra   = 32'h40 + 2 * SPAN;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_busy", BUSYWAIT, 0);
    chk("rst_mem_read", MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_misalign", MISALIGN, 0);
    chk("rst_rdata", READ_DATA, 0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 0);
    chk("rst_mem_wdata", MEM_WRITEDATA == '0, 1);
    @(negedge CLOCK);
    RESET = 1'b1;

    preload(32'h40 >> 2, 32'h1234_5678);
    access(1, 0, 3'd2, 32'h40, 0);
    chk("fill_log_n", mlog.size(), 1);
    if (mlog.size() > 0) begin
      chk("fill_log_w", mlog[0].w, 0);
      chk("fill_log_a", mlog[0].a, 32'h40 >> OFF_W);
    end

    mlog.delete();
    access(0, 1, 3'd0, 32'h41, 32'h0000_00AB);
    access(1, 0, 3'd2, 32'h40, 0);
    access(1, 0, 3'd0, 32'h41, 0);
    access(1, 0, 3'd4, 32'h41, 0);
    access(0, 1, 3'd1, 32'h42, 32'h0000_8001);
    access(1, 0, 3'd1, 32'h42, 0);
    access(1, 0, 3'd5, 32'h42, 0);
    access(1, 0, 3'd2, 32'h42, 0);
    access(0, 1, 3'd1, 32'h43, 32'hDEAD_BEEF);
    access(1, 0, 3'd2, 32'h40, 0);
    chk("hit_no_mem", mlog.size(), 0);

    access(1, 0, 3'd2, conf, 0);
    chk("conf_log_n", mlog.size(), 2);
    if (mlog.size() == 2) begin
      chk("conf_wb_w", mlog[0].w, 1);
      chk("conf_wb_a", mlog[0].a, 32'h40 >> OFF_W);
      chk("conf_rd_w", mlog[1].w, 0);
      chk("conf_rd_a", mlog[1].a, conf >> OFF_W);
    end

    @(posedge CLOCK); #1;
    READ_EN = 1'b1; WRITE_EN = 1'b0; FUNC3 = 3'd2; ADDRESS = ra;
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!MEM_READ && n < 50);
    chk("rst_saw_read", MEM_READ, 1);
    #2 RESET = 1'b0;
    #1;
    chk("arst_mem_read", MEM_READ, 0);
    chk("arst_mem_write", MEM_WRITE, 0);
    chk("arst_busy", BUSYWAIT, 0);
    READ_EN = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    #1 RESET = 1'b1;
    ref_resync();
    mlog.delete();
    access(1, 0, 3'd2, 32'h40, 0);
    chk("post_rst_miss_n", mlog.size(), 1);
    if (mlog.size() > 0) chk("post_rst_miss_a", mlog[0].a, 32'h40 >> OFF_W);

    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 4 * SPAN - 1);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3 == 3'd2) a[1:0] = 2'd0;
      end
      we = $urandom_range(0, 1);
      re = !we || ($urandom_range(0, 3) == 0);
      wd = $urandom;
      access(re, we, f3, a, wd);
    end

    repeat (3) @(posedge CLOCK);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
